// File: rtl/phase_sequencer_if.sv
// Board/decoder-facing bundle of the phase sequencer: run/step controls, fetched word in,
// one-hot phases, opcode bits and status out.
interface phase_sequencer_if #(
  parameter int BusWidth = 8
);
  logic                Run;
  logic                StepReq;
  logic                LoadInst;
  logic [BusWidth-1:0] BusIn;
  logic                Phase0;
  logic                Phase1;
  logic                Phase2;
  logic                Phase3;
  logic                InstrIn0;
  logic                InstrIn1;
  logic                InstrIn2;
  logic                InstrIn3;
  logic [BusWidth-5:0] Operand;
  logic                Halted;
  logic                StepDone;
  logic                ProtoErr;

  modport master (
    output Run, StepReq, LoadInst, BusIn,
    input  Phase0, Phase1, Phase2, Phase3,
    input  InstrIn0, InstrIn1, InstrIn2, InstrIn3, Operand,
    input  Halted, StepDone, ProtoErr
  );

  modport slave (
    input  Run, StepReq, LoadInst, BusIn,
    output Phase0, Phase1, Phase2, Phase3,
    output InstrIn0, InstrIn1, InstrIn2, InstrIn3, Operand,
    output Halted, StepDone, ProtoErr
  );
endinterface

// File: rtl/phase_sequencer.sv
// Machine-cycle sequencer and instruction register: registered one-hot Phase0..3, opcode latch at Phase0.
// Phase0 appears one edge after Run/step edge; instructions always run all 4 phases; no backpressure.
module phase_sequencer #(
  parameter int         BusWidth = 8,
  parameter logic [3:0] HaltOp   = 4'b1111
) (
  input logic              Clock,
  input logic              ResetN,
  phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [3:0]          phase_q, phase_d;
  logic [BusWidth-1:0] instr_q;
  logic                step_prev_q;
  logic                step_done_q, step_done_d;
  logic                proto_err_q;
  logic                step_edge;
  logic                load_ok;

  assign step_edge = bus.StepReq & ~step_prev_q;
  assign load_ok   = bus.LoadInst & phase_q[0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_done_d = 1'b0;
    phase_d     = 4'b0000;
    case (state_q)
      IDLE: begin
        cnt_d = 2'd0;
        // Run has priority; a coincident step edge is dropped.
        if (bus.Run) begin
          state_d = RUN;
        end else if (step_edge) begin
          state_d = STEP;
        end
      end
      RUN, STEP: begin
        if (cnt_q != 2'd3) begin
          cnt_d = cnt_q + 2'd1;
        end else begin
          cnt_d = 2'd0;
          if (instr_q[BusWidth-1 -: 4] == HaltOp) begin
            state_d = HALTED;
          end else if (state_q == STEP) begin
            state_d     = IDLE;
            step_done_d = 1'b1;
          end else if (!bus.Run) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = HALTED;
    endcase
    // Decode from next state so the phase outputs come straight off flops.
    if (state_d == RUN || state_d == STEP) begin
      phase_d[cnt_d] = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      phase_q     <= 4'b0000;
      instr_q     <= '0;
      step_prev_q <= 1'b0;
      step_done_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      step_prev_q <= bus.StepReq;
      step_done_q <= step_done_d;
      if (load_ok) begin
        instr_q <= bus.BusIn;
      end
      if (bus.LoadInst && !phase_q[0]) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign bus.Phase0   = phase_q[0];
  assign bus.Phase1   = phase_q[1];
  assign bus.Phase2   = phase_q[2];
  assign bus.Phase3   = phase_q[3];
  assign bus.InstrIn0 = instr_q[BusWidth-4];
  assign bus.InstrIn1 = instr_q[BusWidth-3];
  assign bus.InstrIn2 = instr_q[BusWidth-2];
  assign bus.InstrIn3 = instr_q[BusWidth-1];
  assign bus.Operand  = instr_q[BusWidth-5:0];
  assign bus.Halted   = (state_q == HALTED);
  assign bus.StepDone = step_done_q;
  assign bus.ProtoErr = proto_err_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed scenarios plus randomized traffic, checked every cycle against an instruction-level model.
module tb_phase_sequencer;

  logic Clock = 1'b0;
  logic ResetN = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  phase_sequencer_if #(.BusWidth(8)) intf ();

  phase_sequencer #(.BusWidth(8), .HaltOp(4'b1111)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (intf.slave)
  );

  always #5 Clock = ~Clock;

  // Model: which phase of the current instruction we are in (-1 = none).
  int         m_phase;
  bit         m_stepmode, m_halted, m_step_done, m_proto, m_prev;
  logic [7:0] m_ir;

  task automatic model_reset();
    m_phase = -1; m_stepmode = 0; m_halted = 0; m_step_done = 0;
    m_proto = 0;  m_prev = 0;     m_ir = 8'h00;
  endtask

  task automatic model_edge();
    logic [7:0] old_ir;
    old_ir      = m_ir;
    m_step_done = 0;
    if (intf.LoadInst) begin
      if (m_phase == 0) m_ir = intf.BusIn;
      else m_proto = 1;
    end
    if (m_halted) begin
    end else if (m_phase < 0) begin
      if (intf.Run) begin
        m_phase = 0; m_stepmode = 0;
      end else if (intf.StepReq && !m_prev) begin
        m_phase = 0; m_stepmode = 1;
      end
    end else if (m_phase < 3) begin
      m_phase++;
    end else if (old_ir[7:4] == 4'hF) begin
      m_halted = 1; m_phase = -1;
    end else if (m_stepmode) begin
      m_phase = -1; m_step_done = 1;
    end else if (!intf.Run) begin
      m_phase = -1;
    end else begin
      m_phase = 0;
    end
    m_prev = intf.StepReq;
  endtask

  function automatic logic [14:0] model_vec();
    logic [3:0] ph;
    ph = 4'b0000;
    if (m_phase >= 0) ph[m_phase] = 1'b1;
    return {ph, m_ir, m_halted, m_step_done, m_proto};
  endfunction

  // {Phase3..0, InstrIn3..0, Operand, Halted, StepDone, ProtoErr}
  function automatic logic [14:0] obs();
    return {intf.Phase3, intf.Phase2, intf.Phase1, intf.Phase0,
            intf.InstrIn3, intf.InstrIn2, intf.InstrIn1, intf.InstrIn0,
            intf.Operand, intf.Halted, intf.StepDone, intf.ProtoErr};
  endfunction

  task automatic tick();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
  endtask

  task automatic do_reset();
    ResetN = 1'b0;
    intf.Run = 0; intf.StepReq = 0; intf.LoadInst = 0; intf.BusIn = 8'h00;
    model_reset();
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (obs() !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", obs(), 15'h0);
    end
    tick();
    vectors++;
    if (obs() !== model_vec()) begin
      miscompares++;
      $display("FAIL reset_idle: got %h expected %h", obs(), model_vec());
    end
  endtask

  task automatic test_run_load();
    logic [3:0] exp_ph;
    logic [14:0] o;
    do_reset();
    intf.Run = 1; intf.BusIn = 8'h15;
    for (int k = 0; k < 12; k++) begin
      intf.LoadInst = (m_phase == 0);
      tick();
      o = obs();
      exp_ph = 4'b0001 << (k % 4);
      vectors++;
      if (o !== model_vec() || o[14:11] !== exp_ph) begin
        miscompares++;
        $display("FAIL run_load k=%0d: got %h model %h phase_req %b", k, o, model_vec(), exp_ph);
      end
      if (k >= 1) begin
        vectors++;
        if (o[10:3] !== 8'h15 || o[2] !== 1'b0) begin
          miscompares++;
          $display("FAIL run_load_ir k=%0d: got ir %h halted %b expected 15 0", k, o[10:3], o[2]);
        end
      end
    end
    intf.LoadInst = 0; intf.Run = 0;
    for (int k = 0; k < 6 && m_phase >= 0; k++) tick();
  endtask

  task automatic test_run_drop();
    logic [3:0] exp_ph [3];
    exp_ph[0] = 4'b0100; exp_ph[1] = 4'b1000; exp_ph[2] = 4'b0000;
    do_reset();
    intf.Run = 1;
    for (int k = 0; k < 8 && m_phase != 1; k++) tick();
    intf.Run = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (obs() !== model_vec() || obs()[14:11] !== exp_ph[k] || intf.StepDone !== 1'b0) begin
        miscompares++;
        $display("FAIL run_drop k=%0d: got %h model %h phase_req %b", k, obs(), model_vec(), exp_ph[k]);
      end
    end
  endtask

  task automatic test_single_step();
    int ph_cycles = 0;
    int done_cycles = 0;
    int done_at = -1;
    do_reset();
    tick();
    intf.StepReq = 1;
    for (int k = 0; k < 10; k++) begin
      if (m_phase == 1) intf.StepReq = 0;
      else if (m_phase == 2) intf.StepReq = 1;
      tick();
      if (obs()[14:11] != 4'b0000) ph_cycles++;
      if (intf.StepDone) begin done_cycles++; done_at = k; end
      vectors++;
      if (obs() !== model_vec()) begin
        miscompares++;
        $display("FAIL step k=%0d: got %h expected %h", k, obs(), model_vec());
      end
    end
    vectors++;
    if (ph_cycles != 4 || done_cycles != 1 || done_at != 4) begin
      miscompares++;
      $display("FAIL step_counts: got phases %0d done %0d at %0d expected 4 1 4", ph_cycles, done_cycles, done_at);
    end
    intf.StepReq = 0;
  endtask

  task automatic test_halt();
    int ph_cycles = 0;
    do_reset();
    intf.Run = 1; intf.BusIn = 8'hF0;
    for (int k = 0; k < 10 && !m_halted; k++) begin
      intf.LoadInst = (m_phase == 0);
      tick();
      if (obs()[14:11] != 4'b0000) ph_cycles++;
    end
    intf.LoadInst = 0;
    vectors++;
    if (ph_cycles != 4 || intf.Halted !== 1'b1 || obs() !== model_vec()) begin
      miscompares++;
      $display("FAIL halt_entry: got phases %0d halted %b expected 4 1", ph_cycles, intf.Halted);
    end
    for (int k = 0; k < 8; k++) begin
      intf.Run = k[0]; intf.StepReq = k[1];
      tick();
      vectors++;
      if (obs()[14:11] !== 4'b0000 || intf.Halted !== 1'b1 || obs() !== model_vec()) begin
        miscompares++;
        $display("FAIL halt_hold k=%0d: got %h expected halted with no phase", k, obs());
      end
    end
    do_reset();
    vectors++;
    if (intf.Halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_clear: got %b expected 0", intf.Halted);
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    intf.Run = 1;
    for (int k = 0; k < 8 && m_phase != 2; k++) tick();
    intf.LoadInst = 1; intf.BusIn = 8'h3A;
    tick();
    intf.LoadInst = 0; intf.Run = 0;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (intf.ProtoErr !== 1'b1 || obs()[10:7] !== 4'h0 || obs() !== model_vec()) begin
        miscompares++;
        $display("FAIL proto_err k=%0d: got %h expected err=1 opcode=0", k, obs());
      end
      tick();
    end
    do_reset();
    vectors++;
    if (intf.ProtoErr !== 1'b0) begin
      miscompares++;
      $display("FAIL proto_clear: got %b expected 0", intf.ProtoErr);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    intf.Run = 1; intf.BusIn = 8'h27;
    for (int k = 0; k < 12 && !(m_phase == 2 && m_ir != 0); k++) begin
      intf.LoadInst = (m_phase == 0);
      tick();
    end
    intf.LoadInst = 0;
    #2 ResetN = 1'b0;
    #1;
    vectors++;
    if (obs() !== 15'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected %h", obs(), 15'h0);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(7) == 0) intf.Run = ~intf.Run;
      if ($urandom_range(2) == 0) intf.StepReq = ~intf.StepReq;
      intf.LoadInst = (m_phase == 0) ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
      intf.BusIn = ($urandom_range(7) == 0) ? {4'hF, 4'($urandom)} : 8'($urandom);
      if ((m_halted && $urandom_range(9) == 0) || $urandom_range(99) == 0) begin
        #2 ResetN = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (obs() !== model_vec()) begin
          miscompares++;
          $display("FAIL rand_reset k=%0d: got %h expected %h", k, obs(), model_vec());
        end
        @(negedge Clock);
        ResetN = 1'b1;
      end
      tick();
      vectors++;
      if (obs() !== model_vec()) begin
        miscompares++;
        $display("FAIL rand k=%0d: got %h expected %h", k, obs(), model_vec());
      end
    end
  endtask

  initial begin
    intf.Run = 0; intf.StepReq = 0; intf.LoadInst = 0; intf.BusIn = 8'h00;
    model_reset();
    test_reset();
    test_run_load();
    test_run_drop();
    test_single_step();
    test_halt();
    test_proto_err();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
